spi_slave_port: RTL and testbench
=================================

SPI_SLAVE_PORT -- requirements
Module: spi_slave_port

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of synchronizer flops on SPI_SS/SPI_SCLK/SPI_MOSI (min 2).
REQ-002 SHALL have parameter DATA_W, default 8, frame width in bits.
REQ-003 SHALL have port CLK_50  input  1  system clock, the only clock; all logic on its rising edge.
REQ-004 SHALL have port RST_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port SPI_SS  input  1  chip select from Xmega master, active-low, asynchronous to CLK_50.
REQ-006 SHALL have port SPI_SCLK  input  1  serial clock from master, asynchronous.
REQ-007 SHALL have port SPI_MOSI  input  1  master-to-slave data.
REQ-008 SHALL have port SPI_MISO  output  1  slave-to-master data.
REQ-009 SHALL have port MISO_OE  output  1  MISO drive enable; top level tri-states SPI_MISO when low.
REQ-010 SHALL have port tx_data  input  DATA_W  byte to return on next frame.
REQ-011 SHALL have port tx_valid  input  1  tx_data offered.
REQ-012 SHALL have port tx_ready  output  1  tx buffer empty; transfer on tx_valid&&tx_ready.
REQ-013 SHALL have port rx_data  output  DATA_W  last received byte.
REQ-014 SHALL have port rx_valid  output  1  rx_data holds an unconsumed byte.
REQ-015 SHALL have port rx_ready  input  1  consumer accepts; rx_valid&&rx_ready clears rx_valid.
REQ-016 SHALL have port busy  output  1  synchronized SS asserted.

Function
REQ-017 SHALL implement SPI mode 0, MSB first: sample MOSI on synchronized SCLK rising edge, update MISO on falling edge.
REQ-018 SHALL use FSM IDLE (SS high), LOAD (one cycle after SS falls), SHIFT (counting bits); SS rising in any state -> IDLE next cycle.
REQ-019 In LOAD, tx shift register SHALL load the tx buffer (marking it empty) if full, else all-ones; MISO = shift MSB, MISO_OE=1.
REQ-020 Each synchronized SCLK rising edge SHALL shift MOSI into rx shift register and increment a bit counter mod DATA_W.
REQ-021 On the DATA_W-th rising edge, rx_data SHALL update and rx_valid SHALL assert on the following CLK_50 cycle; counter wraps to 0.
REQ-022 On the falling edge after counter wrap, tx shift register SHALL reload as in REQ-019 (back-to-back frames, no SS toggle needed).
REQ-023 tx buffer is one entry; tx_ready SHALL be high when empty; a simultaneous accept and frame-load SHALL load the incoming byte directly.
REQ-024 SS deassert mid-frame SHALL discard the partial byte, clear the counter, leave rx_valid/rx_data unchanged, keep the tx buffer.
REQ-025 rx_valid SHALL stay high until rx_ready; byte completion while rx_valid&&!rx_ready is an overrun (REQ-028).
REQ-026 Supported SCLK frequency SHALL be at most CLK_50/8.

Reset
REQ-027 While RST_n low at a CLK_50 edge: FSM=IDLE, counter=0, shift registers=0, tx buffer empty, tx_ready=1, rx_valid=0, rx_data=0, SPI_MISO=1, MISO_OE=0, busy=0, synchronizers preset to idle levels (SS=1, SCLK=0); reset mid-frame aborts the frame.

Configuration
REQ-028 With SPI_SLAVE_OVERRUN_EN defined: output overrun (1 bit, reset 0) SHALL set sticky on overrun, the new byte dropped, cleared only by reset; without it: no overrun port, new byte overwrites rx_data, rx_valid stays 1.

Structure
REQ-029 A shared package spi_pkg SHALL hold the FSM state enum, mode-0 constants and the idle fill value (all-ones).
REQ-030 Sub-module sync_edge SHALL be instantiated per input: SYNC_STAGES synchronizer plus rise/fall pulse outputs.

Verification
REQ-031 Reset then SS low, master sends 0xA5 with tx buffer empty -> MISO returns 0xFF, rx_data=0xA5, one rx_valid.
REQ-032 tx_data=0x3C accepted before SS falls, master sends 0x00 -> MISO shifts 0x3C MSB first, tx_ready back to 1 at LOAD.
REQ-033 Two back-to-back bytes 0x11,0x22 under one SS, rx_ready held high -> two rx_valid pulses, data 0x11 then 0x22.
REQ-034 SS raised after 5 bits of 0xFF, then full byte 0x81 -> only 0x81 reported, no spurious rx_valid.
REQ-035 rx_ready held low, bytes 0x01,0x02 -> with SPI_SLAVE_OVERRUN_EN: rx_data=0x01, overrun=1; without: rx_data=0x02.
REQ-036 RST_n pulsed low after 4 bits -> all outputs at REQ-027 values next cycle; following full frame 0x5A received correctly.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared SPI slave definitions: FSM state encoding, mode-0 idle levels and the idle fill word.
package spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2
    } spi_state_e;

    // Mode 0: SCLK idles low (CPOL=0), data sampled on the rising edge (CPHA=0)
    localparam logic SS_IDLE   = 1'b1;
    localparam logic SCLK_IDLE = 1'b0;
    localparam logic MISO_IDLE = 1'b1;

    localparam int                    MAX_DATA_W = 32;
    localparam logic [MAX_DATA_W-1:0] IDLE_FILL  = '1;

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchronizer for one asynchronous input, with single-cycle rise/fall pulses.
module sync_edge #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain;
    logic              prev;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            chain <= {STAGES{RESET_VAL}};
            prev  <= RESET_VAL;
        end else begin
            chain <= {chain[STAGES-2:0], din};
            prev  <= chain[STAGES-1];
        end
    end

    assign level = chain[STAGES-1];
    assign rise  = level & ~prev;
    assign fall  = ~level & prev;

endmodule

// File: rtl/spi_slave_port.sv
// SPI mode-0 slave sampled entirely in the CLK_50 domain, with one-entry tx buffer and rx handshake.
// Optional sticky overrun flag enabled by defining SPI_SLAVE_OVERRUN_EN.
module spi_slave_port
    import spi_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DATA_W      = 8
) (
    input  logic              CLK_50,
    input  logic              RST_n,
    input  logic              SPI_SS,
    input  logic              SPI_SCLK,
    input  logic              SPI_MOSI,
    output logic              SPI_MISO,
    output logic              MISO_OE,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
`ifdef SPI_SLAVE_OVERRUN_EN
    output logic              overrun,
`endif
    output logic              busy
);

    localparam int CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    logic ss_lvl, ss_rise, ss_fall;
    logic sclk_lvl, sclk_rise, sclk_fall;
    logic mosi_lvl, mosi_rise, mosi_fall;
    logic unused_edges;

    sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(SS_IDLE)) u_sync_ss (
        .clk(CLK_50), .rst_n(RST_n), .din(SPI_SS),
        .level(ss_lvl), .rise(ss_rise), .fall(ss_fall)
    );

    sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(SCLK_IDLE)) u_sync_sclk (
        .clk(CLK_50), .rst_n(RST_n), .din(SPI_SCLK),
        .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
    );

    sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk(CLK_50), .rst_n(RST_n), .din(SPI_MOSI),
        .level(mosi_lvl), .rise(mosi_rise), .fall(mosi_fall)
    );

    assign unused_edges = ss_rise ^ sclk_lvl ^ mosi_rise ^ mosi_fall;

    spi_state_e        state, next_state;
    logic [CNT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] rx_shift, tx_shift, tx_buf;
    logic              tx_full;

    logic              shifting, bit_done, byte_done, frame_load, tx_accept;
    logic [DATA_W-1:0] rx_word, load_word;

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (ss_fall) next_state = ST_LOAD;
            ST_LOAD:  next_state = ST_SHIFT;
            ST_SHIFT: next_state = ST_SHIFT;
            default:  next_state = ST_IDLE;
        endcase
        if (ss_lvl) next_state = ST_IDLE;
    end

    assign shifting  = (state == ST_SHIFT) && !ss_lvl;
    assign bit_done  = shifting && sclk_rise;
    assign byte_done = bit_done && (bit_cnt == LAST_BIT);
    assign rx_word   = {rx_shift[DATA_W-2:0], mosi_lvl};
    assign tx_accept = tx_valid && tx_ready;

    // Counter back at zero on a falling edge means a byte just finished: start the next one
    assign frame_load = !ss_lvl && ((state == ST_LOAD) ||
                                    (shifting && sclk_fall && (bit_cnt == '0)));

    // An offer arriving in the same cycle as the load bypasses the buffer
    assign load_word = tx_full   ? tx_buf  :
                       tx_accept ? tx_data : IDLE_FILL[DATA_W-1:0];

    always_ff @(posedge CLK_50) begin
        if (!RST_n) begin
            state    <= ST_IDLE;
            bit_cnt  <= '0;
            rx_shift <= '0;
            tx_shift <= '0;
            tx_buf   <= '0;
            tx_full  <= 1'b0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
`ifdef SPI_SLAVE_OVERRUN_EN
            overrun  <= 1'b0;
`endif
        end else begin
            state <= next_state;

            if (state == ST_IDLE || ss_lvl) begin
                bit_cnt  <= '0;
                rx_shift <= '0;
            end else if (bit_done) begin
                rx_shift <= rx_word;
                bit_cnt  <= byte_done ? '0 : bit_cnt + 1'b1;
            end

            if (frame_load) begin
                tx_shift <= load_word;
            end else if (shifting && sclk_fall) begin
                tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
            end

            if (frame_load && tx_full) begin
                tx_full <= 1'b0;
            end else if (tx_accept && !frame_load) begin
                tx_buf  <= tx_data;
                tx_full <= 1'b1;
            end

            if (rx_valid && rx_ready) rx_valid <= 1'b0;
            if (byte_done) begin
`ifdef SPI_SLAVE_OVERRUN_EN
                if (rx_valid && !rx_ready) begin
                    overrun <= 1'b1;
                end else begin
                    rx_data  <= rx_word;
                    rx_valid <= 1'b1;
                end
`else
                rx_data  <= rx_word;
                rx_valid <= 1'b1;
`endif
            end
        end
    end

    assign tx_ready = !tx_full;
    assign busy     = !ss_lvl;
    assign MISO_OE  = (state != ST_IDLE);
    assign SPI_MISO = MISO_OE ? tx_shift[DATA_W-1] : MISO_IDLE;

endmodule

// File: tb/tb_spi_slave_port.sv
// Directed bench for spi_slave_port: bit-banged mode-0 master, queue-based rx model, literal pins.
module tb_spi_slave_port;

    logic       CLK_50 = 1'b0;
    logic       RST_n, SPI_SS, SPI_SCLK, SPI_MOSI;
    logic       SPI_MISO, MISO_OE;
    logic [7:0] tx_data, rx_data;
    logic       tx_valid, tx_ready, rx_valid, rx_ready, busy;
`ifdef SPI_SLAVE_OVERRUN_EN
    logic       overrun;
`endif

    always #10 CLK_50 = ~CLK_50;

    spi_slave_port #(.SYNC_STAGES(2), .DATA_W(8)) dut (
        .CLK_50(CLK_50), .RST_n(RST_n),
        .SPI_SS(SPI_SS), .SPI_SCLK(SPI_SCLK), .SPI_MOSI(SPI_MOSI),
        .SPI_MISO(SPI_MISO), .MISO_OE(MISO_OE),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
`ifdef SPI_SLAVE_OVERRUN_EN
        .overrun(overrun),
`endif
        .busy(busy)
    );

    int         tests = 0;
    int         fails = 0;
    int         hs_count = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_head;
    logic       exp_ovr = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Every accepted byte must be the next one the master completed, in order
    always @(negedge CLK_50) begin
        if (RST_n === 1'b1 && rx_valid === 1'b1 && rx_ready === 1'b1) begin
            hs_count++;
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL rx_spurious: got 0x%0h expected no byte", rx_data);
            end else begin
                exp_head = exp_q.pop_front();
                if (rx_data !== exp_head) begin
                    fails++;
                    $display("FAIL rx_stream: got 0x%0h expected 0x%0h", rx_data, exp_head);
                end
            end
        end
    end

    // A completed byte that finds an unconsumed byte with rx_ready low is an overrun
    task automatic model_frame_done(input logic [7:0] b);
        if (exp_q.size() > 0 && !rx_ready) begin
`ifdef SPI_SLAVE_OVERRUN_EN
            exp_ovr = 1'b1;
`else
            void'(exp_q.pop_back());
            exp_q.push_back(b);
`endif
        end else begin
            exp_q.push_back(b);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge CLK_50);
    endtask

    // 16 CLK_50 cycles per SCLK period, well inside the CLK_50/8 limit
    task automatic spi_bits(input logic [7:0] mosi_b, input int n, output logic [7:0] miso_b);
        miso_b = 8'h00;
        for (int i = 7; i > 7 - n; i--) begin
            SPI_MOSI = mosi_b[i];
            wait_clk(8);
            miso_b   = {miso_b[6:0], SPI_MISO};
            SPI_SCLK = 1'b1;
            if (n == 8 && i == 0) model_frame_done(mosi_b);
            wait_clk(8);
            SPI_SCLK = 1'b0;
        end
    endtask

    task automatic tx_offer(input logic [7:0] b);
        int n;
        tx_data  = b;
        tx_valid = 1'b1;
        n = 0;
        while (!tx_ready && n < 50) begin
            wait_clk(1);
            n++;
        end
        if (n >= 50) check("tx_offer_timeout", 32'(n), 32'(0));
        wait_clk(1);
        tx_valid = 1'b0;
    endtask

    task automatic ss_low();
        SPI_SS = 1'b0;
        wait_clk(8);
    endtask

    task automatic ss_high();
        wait_clk(8);
        SPI_SS = 1'b1;
        wait_clk(8);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tx_ready"}, 32'(tx_ready), 32'(1));
        check({tag, "_rx_valid"}, 32'(rx_valid), 32'(0));
        check({tag, "_rx_data"},  32'(rx_data),  32'(0));
        check({tag, "_miso"},     32'(SPI_MISO), 32'(1));
        check({tag, "_miso_oe"},  32'(MISO_OE),  32'(0));
        check({tag, "_busy"},     32'(busy),     32'(0));
`ifdef SPI_SLAVE_OVERRUN_EN
        check({tag, "_overrun"},  32'(overrun),  32'(0));
`endif
    endtask

    initial begin
        logic [7:0] m1, m2;
        int         hs0;

        RST_n = 1'b0; SPI_SS = 1'b1; SPI_SCLK = 1'b0; SPI_MOSI = 1'b0;
        tx_data = 8'h00; tx_valid = 1'b0; rx_ready = 1'b0;
        wait_clk(3);
        check_reset_outputs("reset");
        RST_n = 1'b1;
        wait_clk(2);

        // Empty tx buffer: slave returns the all-ones fill
        rx_ready = 1'b1;
        hs0 = hs_count;
        ss_low();
        spi_bits(8'hA5, 8, m1);
        ss_high();
        check("a5_miso", 32'(m1), 32'hFF);
        check("a5_count", 32'(hs_count - hs0), 32'(1));
        check("a5_rx_data", 32'(rx_data), 32'hA5);
        check("a5_rx_valid_cleared", 32'(rx_valid), 32'(0));

        // Byte offered before the frame is shifted out, buffer frees at LOAD
        hs0 = hs_count;
        tx_offer(8'h3C);
        check("3c_tx_ready_full", 32'(tx_ready), 32'(0));
        SPI_SS = 1'b0;
        wait_clk(6);
        check("3c_tx_ready_load", 32'(tx_ready), 32'(1));
        check("3c_busy", 32'(busy), 32'(1));
        check("3c_miso_oe", 32'(MISO_OE), 32'(1));
        wait_clk(2);
        spi_bits(8'h00, 8, m1);
        ss_high();
        check("3c_miso", 32'(m1), 32'h3C);
        check("3c_count", 32'(hs_count - hs0), 32'(1));
        check("3c_rx_data", 32'(rx_data), 32'h00);

        // Two frames under one SS; a byte offered during the first returns on the second
        hs0 = hs_count;
        ss_low();
        tx_offer(8'h96);
        check("b2b_tx_ready_full", 32'(tx_ready), 32'(0));
        spi_bits(8'h11, 8, m1);
        spi_bits(8'h22, 8, m2);
        ss_high();
        check("b2b_miso1", 32'(m1), 32'hFF);
        check("b2b_miso2", 32'(m2), 32'h96);
        check("b2b_count", 32'(hs_count - hs0), 32'(2));
        check("b2b_tx_ready", 32'(tx_ready), 32'(1));
        check("b2b_rx_data", 32'(rx_data), 32'h22);

        // Aborted partial frame leaves no trace
        hs0 = hs_count;
        ss_low();
        spi_bits(8'hFF, 5, m1);
        ss_high();
        check("abort_busy", 32'(busy), 32'(0));
        check("abort_miso_oe", 32'(MISO_OE), 32'(0));
        check("abort_count", 32'(hs_count - hs0), 32'(0));
        check("abort_rx_data", 32'(rx_data), 32'h22);
        ss_low();
        spi_bits(8'h81, 8, m1);
        ss_high();
        check("abort_next_count", 32'(hs_count - hs0), 32'(1));
        check("abort_next_rx_data", 32'(rx_data), 32'h81);

        // Consumer stalled across two completed bytes
        rx_ready = 1'b0;
        hs0 = hs_count;
        ss_low();
        spi_bits(8'h01, 8, m1);
        spi_bits(8'h02, 8, m2);
        ss_high();
        check("ovr_rx_valid", 32'(rx_valid), 32'(1));
`ifdef SPI_SLAVE_OVERRUN_EN
        check("ovr_rx_data", 32'(rx_data), 32'h01);
        check("ovr_flag", 32'(overrun), 32'(1));
        check("ovr_model", 32'(overrun), 32'(exp_ovr));
`else
        check("ovr_rx_data", 32'(rx_data), 32'h02);
`endif
        rx_ready = 1'b1;
        wait_clk(4);
        check("ovr_drain_count", 32'(hs_count - hs0), 32'(1));
        check("ovr_rx_valid_cleared", 32'(rx_valid), 32'(0));
`ifdef SPI_SLAVE_OVERRUN_EN
        check("ovr_sticky", 32'(overrun), 32'(1));
`endif

        // Reset mid-frame aborts it; next frame is received cleanly
        ss_low();
        spi_bits(8'hF0, 4, m1);
        RST_n    = 1'b0;
        SPI_SS   = 1'b1;
        SPI_SCLK = 1'b0;
        exp_q.delete();
        exp_ovr = 1'b0;
        wait_clk(1);
        check_reset_outputs("midrst");
        RST_n = 1'b1;
        wait_clk(4);
        hs0 = hs_count;
        ss_low();
        spi_bits(8'h5A, 8, m1);
        ss_high();
        check("5a_miso", 32'(m1), 32'hFF);
        check("5a_count", 32'(hs_count - hs0), 32'(1));
        check("5a_rx_data", 32'(rx_data), 32'h5A);

        check("model_queue_empty", 32'(exp_q.size()), 32'(0));
`ifdef SPI_SLAVE_OVERRUN_EN
        check("final_overrun", 32'(overrun), 32'(exp_ovr));
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
